bcd_seq_conv: RTL

Sequential (shift-and-add-3) binary-to-BCD converter for the PN sequence display path. It sits between the masked-output register of the PN generator top level and the onboard seven-segment driver. It replaces the combinational BCD conversion with a start/done handshake, one bit per clock. The output digits are held stable between conversions, so the display never shows intermediate values.

---
 rtl/bcd_seq_conv.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bcd_seq_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/done handshake.
// Converts one input bit per clock; published digits hold until the next result.
module bcd_seq_conv #(
    parameter int N = 13,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] bin_in,
    output logic [3:0]   one,
    output logic [3:0]   ten,
    output logic [3:0]   hundred,
    output logic [3:0]   thousand,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     bin_q, bin_d;
    logic [4*D-1:0]   bcd_q, bcd_d;
    logic             sovf_q, sovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      dig_q, dig_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [4*D-1:0]   adj;
    logic             carry;

    // Every digit >= 5 is bumped by 3 so that the following shift never leaves a digit above 9.
    function automatic logic [4*D-1:0] add3(input logic [4*D-1:0] s);
        logic [4*D-1:0] r;
        r = s;
        for (int i = 0; i < D; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            sovf_q  <= 1'b0;
            cnt_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            sovf_q  <= sovf_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        sovf_d  = sovf_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        adj     = add3(bcd_q);
        carry   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    sovf_d  = 1'b0;
                    cnt_d   = CW'(N);
                    state_d = CONV;
                end
            end
            CONV: begin
                {carry, bcd_d} = {adj, bin_q[N-1]};
                bin_d  = bin_q << 1;
                sovf_d = sovf_q | carry;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Saturate to all nines when the value did not fit in D digits.
                if (sovf_q) begin
                    dig_d = {4{4'h9}};
                    ovf_d = 1'b1;
                end else begin
                    dig_d = 16'(bcd_q);
                    ovf_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign one      = dig_q[3:0];
    assign ten      = dig_q[7:4];
    assign hundred  = dig_q[11:8];
    assign thousand = dig_q[15:12];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ovf      = ovf_q;

endmodule
